// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped fetch-stage BTB. Every cycle the fetch PC is looked up
//   combinationally against registered table state. On a hit, the buffer
//   supplies a predicted-taken flag and the stored target. The table is
//   trained by execute-stage branch/jump resolution.
//
//   Each entry holds a valid bit, a tag, a target, a 2-bit saturating
//   direction counter and a jump flag.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   i_flush        invalidate every entry on the next edge
//   i_lookup_pc    fetch PC looked up this cycle
//   o_hit          valid entry with matching tag
//   o_pred_taken   hit and counter MSB set
//   o_target       stored target on hit, else 0
//   i_upd_valid    a branch/jump resolved this cycle
//   i_upd_pc       PC of the resolved instruction
//   i_upd_target   resolved target
//   i_upd_taken    resolved direction (1 = taken)
//   i_upd_is_jump  unconditional jump, always treated as taken
// ---------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int ENTRIES    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_target,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_taken,
  input  logic                  i_upd_is_jump
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  logic [ENTRIES-1:0]    valid_q;
  logic [ENTRIES-1:0]    jmp_q;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  // Lookup path
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx = i_lookup_pc[IDX+1:2];
  assign lk_tag = i_lookup_pc[ADDR_WIDTH-1:IDX+2];

  // valid_q clears asynchronously, so all outputs drop during reset.
  assign o_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign o_pred_taken = o_hit && ctr_q[lk_idx][1];
  assign o_target     = o_hit ? target_q[lk_idx] : '0;

  // Update path
  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             eff_taken;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;

  assign up_idx    = i_upd_pc[IDX+1:2];
  assign up_tag    = i_upd_pc[ADDR_WIDTH-1:IDX+2];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign eff_taken = i_upd_taken || i_upd_is_jump;
  assign ctr_cur   = ctr_q[up_idx];

  // Saturating counter step for a hit entry; never wraps.
  always_comb begin
    ctr_next = ctr_cur;
    if (i_upd_is_jump) begin
      ctr_next = 2'b11;
    end else if (i_upd_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      jmp_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (i_flush) begin
      // Flush takes priority over a same-cycle update.
      valid_q <= '0;
    end else if (i_upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
        if (eff_taken) target_q[up_idx] <= i_upd_target;
      end else if (eff_taken) begin
        // Allocation overwrites whatever aliased entry lived at this index.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= i_upd_target;
        ctr_q[up_idx]    <= i_upd_is_jump ? 2'b11 : 2'b10;
        jmp_q[up_idx]    <= i_upd_is_jump;
      end
    end
  end

  // The jump flag is kept for future use. The PC byte-offset bits are
  // ignored by design.
  logic unused_bits;
  assign unused_bits = ^{jmp_q, i_lookup_pc[1:0], i_upd_pc[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic [31:0] i_lookup_pc;
  logic        o_hit;
  logic        o_pred_taken;
  logic [31:0] o_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic [31:0] i_upd_target;
  logic        i_upd_taken;
  logic        i_upd_is_jump;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRIES(16), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (i_flush),
    .i_lookup_pc  (i_lookup_pc),
    .o_hit        (o_hit),
    .o_pred_taken (o_pred_taken),
    .o_target     (o_target),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_target (i_upd_target),
    .i_upd_taken  (i_upd_taken),
    .i_upd_is_jump(i_upd_is_jump)
  );

  // Reference model: one record per slot, slot = word address mod 16,
  // tag = PC / 64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 64);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
  endtask

  task automatic m_update(input logic uv, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic jp, input logic fl);
    int s;
    s = slot(pc);
    if (fl) begin
      m_clear();
    end else if (uv) begin
      if (m_hit(pc)) begin
        if (jp) begin
          m_ctr[s] = 3;
          m_tgt[s] = tgt;
        end else if (tk) begin
          m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = tgt;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (tk || jp) begin
        m_valid[s] = 1;
        m_tag[s]   = pc / 64;
        m_tgt[s]   = tgt;
        m_ctr[s]   = jp ? 3 : 2;
      end
    end
  endtask

  // One clock: drive at negedge, check lookup against model (pre-update), then
  // let the edge happen and advance the model.
  task automatic cycle(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic ut, input logic uj,
                       input logic fl);
    bit h;
    @(negedge clk);
    i_lookup_pc   = lk;
    i_upd_valid   = uv;
    i_upd_pc      = upc;
    i_upd_target  = utgt;
    i_upd_taken   = ut;
    i_upd_is_jump = uj;
    i_flush       = fl;
    #1;
    h = m_hit(lk);
    chk("model_hit",  {31'd0, o_hit},        {31'd0, h});
    chk("model_pred", {31'd0, o_pred_taken}, {31'd0, h && (m_ctr[slot(lk)] >= 2)});
    chk("model_tgt",  o_target,              h ? m_tgt[slot(lk)] : 32'd0);
    @(posedge clk);
    m_update(uv, upc, utgt, ut, uj, fl);
  endtask

  // Idle lookup checked against constants.
  task automatic peek(input string tag, input logic [31:0] lk, input logic h,
                      input logic p, input logic [31:0] t);
    @(negedge clk);
    i_lookup_pc = lk;
    i_upd_valid = 1'b0;
    i_flush     = 1'b0;
    #1;
    chk({tag, "_hit"},  {31'd0, o_hit},        {31'd0, h});
    chk({tag, "_pred"}, {31'd0, o_pred_taken}, {31'd0, p});
    chk({tag, "_tgt"},  o_target,              t);
  endtask

  function automatic logic [31:0] rpc();
    int unsigned v;
    v = 32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
        | $urandom_range(0, 3);
    return v;
  endfunction

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0050;
  localparam logic [31:0] PC_C = 32'h0040_0020;
  localparam logic [31:0] PC_D = 32'h0040_0030;
  localparam logic [31:0] T_A  = 32'h0040_0100;
  localparam logic [31:0] T_B  = 32'h0040_0500;
  localparam logic [31:0] T_C  = 32'h0040_0400;

  initial begin
    rst_n = 1'b0;
    i_flush = 1'b0;
    i_lookup_pc = PC_A;
    i_upd_valid = 1'b0;
    i_upd_pc = '0;
    i_upd_target = '0;
    i_upd_taken = 1'b0;
    i_upd_is_jump = 1'b0;
    m_clear();
    for (int i = 0; i < 16; i++) begin
      m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    #12;
    chk("rst_hit",  {31'd0, o_hit},        32'd0);
    chk("rst_pred", {31'd0, o_pred_taken}, 32'd0);
    chk("rst_tgt",  o_target,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    peek("post_rst", PC_A, 1'b0, 1'b0, 32'd0);

    // Allocation by a conditional taken branch.
    cycle(PC_A, 1, PC_A, T_A, 1, 0, 0);
    peek("alloc", PC_A, 1'b1, 1'b1, T_A);

    // Counter walks down and saturates at 00.
    cycle(PC_A, 1, PC_A, 32'h1111_0000, 0, 0, 0);
    peek("nt1", PC_A, 1'b1, 1'b0, T_A);
    for (int i = 0; i < 4; i++) cycle(PC_A, 1, PC_A, 32'h2222_0000, 0, 0, 0);
    peek("nt_sat", PC_A, 1'b1, 1'b0, T_A);
    cycle(PC_A, 1, PC_A, T_A, 1, 0, 0);
    peek("tk_from0", PC_A, 1'b1, 1'b0, T_A);
    for (int i = 0; i < 3; i++) cycle(PC_A, 1, PC_A, T_A, 1, 0, 0);
    // At 11 after saturation; one not-taken must leave it predicting taken.
    cycle(PC_A, 1, PC_A, T_A, 0, 0, 0);
    peek("tk_sat", PC_A, 1'b1, 1'b1, T_A);

    // Aliasing on the same index.
    cycle(PC_B, 1, PC_B, T_B, 0, 0, 0);
    peek("alias_nt_a", PC_A, 1'b1, 1'b1, T_A);
    peek("alias_nt_b", PC_B, 1'b0, 1'b0, 32'd0);
    cycle(PC_B, 1, PC_B, T_B, 1, 0, 0);
    peek("alias_tk_a", PC_A, 1'b0, 1'b0, 32'd0);
    peek("alias_tk_b", PC_B, 1'b1, 1'b1, T_B);

    // Jump allocates with a strong counter even though taken=0.
    cycle(PC_C, 1, PC_C, T_C, 0, 1, 0);
    peek("jump", PC_C, 1'b1, 1'b1, T_C);
    cycle(PC_C, 1, PC_C, 32'h3333_0000, 0, 0, 0);
    peek("jump_ctr11", PC_C, 1'b1, 1'b1, T_C);

    // Same-index lookup and update: old contents visible this cycle.
    cycle(PC_C, 1, PC_C, 32'h4444_0000, 0, 0, 0);
    peek("same_cyc_after", PC_C, 1'b1, 1'b0, T_C);

    // Flush wins over a same-cycle update.
    cycle(PC_C, 1, PC_D, 32'h0040_0800, 1, 0, 1);
    peek("flush_d", PC_D, 1'b0, 1'b0, 32'd0);
    peek("flush_c", PC_C, 1'b0, 1'b0, 32'd0);

    // Randomized traffic over a small PC pool so hits and aliasing are common.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] upc;
      logic [31:0] lk;
      upc = rpc();
      lk  = ($urandom_range(0, 3) == 0) ? upc : rpc();
      cycle(lk, $urandom_range(0, 3) != 0, upc, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            $urandom_range(0, 59) == 0);
    end

    // Reset dropped between edges clears outputs before the next edge.
    cycle(PC_C, 1, PC_C, T_C, 0, 1, 0);
    peek("pre_rst", PC_C, 1'b1, 1'b1, T_C);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hit",  {31'd0, o_hit},        32'd0);
    chk("async_rst_pred", {31'd0, o_pred_taken}, 32'd0);
    chk("async_rst_tgt",  o_target,              32'd0);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    peek("after_rst", PC_C, 1'b0, 1'b0, 32'd0);
    cycle(PC_C, 1, PC_A, T_A, 1, 0, 0);
    cycle(PC_A, 0, PC_A, T_A, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
